// File: rtl/serial_mag_compare_ctrl.sv
// Serial magnitude comparator controller.
// Compares two WIDTH-bit unsigned operands two bits per cycle, MSB-first,
// stopping at the first differing bit pair. One-hot less/equal/greater
// flags are registered together with a single-cycle done pulse.
module serial_mag_compare_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_less_B,
  output logic             A_equal_B,
  output logic             A_greater_B
);

  // Odd or too-narrow widths would leave a dangling single bit.
  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_mag_compare_ctrl: WIDTH must be even and >= 2");
  end

  localparam int unsigned CntW = $clog2(WIDTH / 2 + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_sa, w_sa_d;
  logic [WIDTH-1:0] r_sb, w_sb_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  // Flag vector ordering: {less, equal, greater}.
  logic [2:0]       r_flags, w_flags_d;

  logic [1:0]       w_pair_a, w_pair_b;
  logic             w_pair_lt, w_pair_gt;

  // The shared 2-bit compare slice, fed straight from the shift register tops.
  always_comb begin
    w_pair_a  = r_sa[WIDTH-1 -: 2];
    w_pair_b  = r_sb[WIDTH-1 -: 2];
    w_pair_lt = (w_pair_a < w_pair_b);
    w_pair_gt = (w_pair_a > w_pair_b);
  end

  // Next-state and datapath next values; flags change only on the edge into StDone.
  always_comb begin
    w_state_d = r_state;
    w_sa_d    = r_sa;
    w_sb_d    = r_sb;
    w_cnt_d   = r_cnt;
    w_flags_d = r_flags;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_sa_d    = A;
          w_sb_d    = B;
          w_cnt_d   = CntInit;
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (w_pair_lt || w_pair_gt) begin
          w_flags_d = {w_pair_lt, 1'b0, w_pair_gt};
          w_state_d = StDone;
        end else if (r_cnt == '0) begin
          w_flags_d = 3'b010;
          w_state_d = StDone;
        end else begin
          w_sa_d  = r_sa << 2;
          w_sb_d  = r_sb << 2;
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State register; reset aborts any compare in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Operand shift registers and pair counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_cnt <= '0;
    end else begin
      r_sa  <= w_sa_d;
      r_sb  <= w_sb_d;
      r_cnt <= w_cnt_d;
    end
  end

  // Result flags; hold across new starts until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 3'b000;
    end else begin
      r_flags <= w_flags_d;
    end
  end

  // Status and result outputs decoded from registered state.
  always_comb begin
    busy        = (r_state != StIdle);
    done        = (r_state == StDone);
    A_less_B    = r_flags[2];
    A_equal_B   = r_flags[1];
    A_greater_B = r_flags[0];
  end

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Self-checking bench for serial_mag_compare_ctrl: WIDTH=8 and WIDTH=2 instances
// checked cycle by cycle against a plain-arithmetic reference model.
module tb_serial_mag_compare_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       s8;
  logic [7:0] a8, b8;
  logic       busy8, done8, lt8, eq8, gt8;

  logic       s2;
  logic [1:0] a2, b2;
  logic       busy2, done2, lt2, eq2, gt2;

  int         n_total = 0;
  int         n_bad = 0;
  logic [2:0] exp8 = 3'b000;
  logic [2:0] exp2 = 3'b000;

  always #5 clk = ~clk;

  serial_mag_compare_ctrl #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s8),
    .A          (a8),
    .B          (b8),
    .busy       (busy8),
    .done       (done8),
    .A_less_B   (lt8),
    .A_equal_B  (eq8),
    .A_greater_B(gt8)
  );

  serial_mag_compare_ctrl #(.WIDTH(2)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s2),
    .A          (a2),
    .B          (b2),
    .busy       (busy2),
    .done       (done2),
    .A_less_B   (lt2),
    .A_equal_B  (eq2),
    .A_greater_B(gt2)
  );

  task automatic check_eq(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference flags {less, equal, greater} from ordinary unsigned comparison.
  function automatic logic [2:0] ref_flags(input int unsigned a, input int unsigned b);
    return {(a < b), (a == b), (a > b)};
  endfunction

  // Pairs examined: position of the most significant differing bit, in pairs from the top.
  function automatic int ref_pairs(input int unsigned a, input int unsigned b, input int w);
    int unsigned diff;
    int          h;
    if (a == b) return w / 2;
    diff = a ^ b;
    h = 0;
    for (int i = 0; i < w; i++) if (diff[i]) h = i;
    return (w - 1 - h) / 2 + 1;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after busy falls.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit hold,
                      input string tag);
    int         k;
    logic [2:0] want;
    k    = ref_pairs(a, b, 8);
    want = ref_flags(a, b);
    s8 = 1'b1;
    a8 = a;
    b8 = b;
    @(posedge clk);
    @(negedge clk);
    if (!hold) s8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    check_eq({tag, ":busy_e0"}, 3'(busy8), 3'd1);
    check_eq({tag, ":done_e0"}, 3'(done8), 3'd0);
    check_eq({tag, ":flags_e0"}, {lt8, eq8, gt8}, exp8);
    for (int j = 1; j <= k; j++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (j == k) exp8 = want;
      check_eq({tag, ":busy_run"}, 3'(busy8), 3'd1);
      check_eq({tag, ":done"}, 3'(done8), 3'(j == k));
      check_eq({tag, ":flags"}, {lt8, eq8, gt8}, exp8);
    end
    @(negedge clk);
    check_eq({tag, ":busy_idle"}, 3'(busy8), 3'd0);
    check_eq({tag, ":done_idle"}, 3'(done8), 3'd0);
    check_eq({tag, ":flags_idle"}, {lt8, eq8, gt8}, exp8);
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b);
    s2 = 1'b1;
    a2 = a;
    b2 = b;
    @(posedge clk);
    @(negedge clk);
    s2 = 1'b0;
    a2 = ~a;
    b2 = ~b;
    check_eq("w2:busy_e0", 3'(busy2), 3'd1);
    check_eq("w2:done_e0", 3'(done2), 3'd0);
    @(negedge clk);
    exp2 = ref_flags(a, b);
    check_eq("w2:done", 3'(done2), 3'd1);
    check_eq("w2:flags", {lt2, eq2, gt2}, exp2);
    check_eq("w2:onehot", 3'($countones({lt2, eq2, gt2})), 3'd1);
    @(negedge clk);
    check_eq("w2:busy_idle", 3'(busy2), 3'd0);
    check_eq("w2:done_idle", 3'(done2), 3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    s8 = 1'b0;
    a8 = '0;
    b8 = '0;
    s2 = 1'b0;
    a2 = '0;
    b2 = '0;

    #1;
    check_eq("rst:busy8", 3'(busy8), 3'd0);
    check_eq("rst:done8", 3'(done8), 3'd0);
    check_eq("rst:flags8", {lt8, eq8, gt8}, 3'b000);
    check_eq("rst:busy2", 3'(busy2), 3'd0);
    check_eq("rst:flags2", {lt2, eq2, gt2}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases: full-length equal, MSB-pair decision, last-pair decision.
    run8(8'hA5, 8'hA5, 1'b0, "eq_a5");
    run8(8'h80, 8'h7F, 1'b0, "gt_msb");
    run8(8'h34, 8'h35, 1'b0, "lt_lsb");

    // start held high: each compare is taken on the first idle edge, operands scrambled.
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = (i % 2 == 0) ? ra : (ra ^ (8'd1 << $urandom_range(0, 7)));
      run8(ra, rb, 1'b1, "held");
    end
    s8 = 1'b0;
    @(negedge clk);

    // Random compares biased towards equal and near-equal operands.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = 8'($urandom);
        default: rb = ra ^ (8'd1 << $urandom_range(0, 7));
      endcase
      run8(ra, rb, 1'b0, "rand");
    end

    // Reset in the second RUN cycle of an equal compare.
    s8 = 1'b1;
    a8 = 8'hA5;
    b8 = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    s8 = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp8 = 3'b000;
    check_eq("abort:busy", 3'(busy8), 3'd0);
    check_eq("abort:done", 3'(done8), 3'd0);
    check_eq("abort:flags", {lt8, eq8, gt8}, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort:done_hold", 3'(done8), 3'd0);
    end
    rst_n = 1'b1;
    run8(8'hA5, 8'hA5, 1'b0, "post_rst");
    run8(8'h12, 8'hF0, 1'b0, "post_rst2");

    // Exhaustive WIDTH=2.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        run2(2'(a), 2'(b));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
